mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Single-port synchronous word memory acting as the responder for the RAM read/write handshake.
- Serves two initiators: the instruction-fetch stage (read-only) and the memory-access stage (read/write).
- Each initiator sees its own re/busy/done/data port. The block queues one request per port, arbitrates MEM over IF, and answers after a fixed access latency.
- Sits between the pipeline stages and the simulated main memory.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both ports
- DATA_WIDTH, 32, word width; fixed at 32 for byte select
- DEPTH_LOG2, 10, log2 of word count (1024 words)
- LATENCY, 3, cycles from request cycle to done cycle; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- if_re_i  in  1  IF read request
- if_addr_i  in  ADDR_WIDTH  IF byte address
- if_data_o  out  DATA_WIDTH  IF read data; valid in done cycle, held until next IF done
- if_busy_o  out  1  IF request outstanding, not yet done
- if_done_o  out  1  one-cycle IF completion pulse
- mem_re_i  in  1  MEM read request
- mem_we_i  in  1  MEM write request
- mem_addr_i  in  ADDR_WIDTH  MEM byte address
- mem_wdata_i  in  DATA_WIDTH  MEM write data
- mem_sel_i  in  4  MEM byte enables; bit n covers bits [8n+7:8n]
- mem_rdata_o  out  DATA_WIDTH  MEM read data; held until next MEM read done
- mem_busy_o  out  1  MEM request outstanding
- mem_done_o  out  1  one-cycle MEM completion pulse; also pulses for writes

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Pending slots are cleared; engine returns to IDLE; counter is 0.
  - Memory array contents are not reset.
  - Reset mid-access aborts the access: no done, no write commit if not yet committed.
- Acceptance:
  - A port's request is accepted at the rising edge where (re or we) is high and that port's busy_o is 0.
  - Acceptance latches the address, wdata, sel and type into that port's pending slot.
  - Requests presented while busy_o=1 are ignored, not queued.
- Word index is addr[DEPTH_LOG2+1:2]. Bits [1:0] and upper bits are ignored, so addresses wrap.
- On MEM, mem_we_i=1 means a write regardless of mem_re_i.
- busy_o goes high the cycle after acceptance. It stays high until, and drops in, that port's done cycle. Exception: with LATENCY=1 and an idle engine, busy_o never rises.
- Engine states:
  - IDLE: no access in progress.
  - SERVE_MEM, SERVE_IF: an access is in progress; a counter counts from LATENCY-1 down to 0.
- Arbitration:
  - From IDLE, or at the completing edge of an access, the engine starts the pending MEM slot if any, else the pending IF slot, else goes to IDLE.
  - A request accepted at the same edge is eligible immediately (zero extra cycles).
- Timing: for a request presented in cycle C with an idle engine, done_o=1 in cycle C+LATENCY.
- Completion cycle:
  - The read data register is updated (mem_rdata_o or if_data_o); the pending slot is cleared; done_o=1 and busy_o=0 for exactly one cycle.
  - The same port may present a new request in its done cycle. It is accepted back-to-back, so done recurs every LATENCY cycles.
- Writes commit to the array at the completing edge. A read of the same word served later returns the new data.
- Queued request: if IF is queued behind MEM, IF done is LATENCY cycles after MEM done.
- Simultaneous requests from both ports on an idle engine: both are accepted, MEM is served first.
- Done pulses of the two ports never coincide.

Optional Feature:
- Macro MEM_RESPONDER_BYTE_SEL_EN.
- Defined: MEM writes update only the bytes whose mem_sel_i bit was 1 at acceptance. sel=0000 still pulses done but leaves memory unchanged.
- Undefined: mem_sel_i is ignored and every write updates the full word. The port remains present.

Test Plan:
- Reset, preload word 4 = 0x00000013; IF reads addr 0x10 in cycle 0 -> if_busy_o=1 in cycles 1-2, if_done_o=1 and if_data_o=0x00000013 in cycle 3, data held afterward.
- IF holds if_re_i=1 with addr 0x0,0x4,0x8 issued in each done cycle -> if_done_o every 3 cycles, data matches the three words in order.
- IF and MEM both request in cycle 0 (MEM writes 0xDEADBEEF to 0x20, IF reads 0x20) -> mem_done_o in cycle 3, if_done_o in cycle 6 with if_data_o=0xDEADBEEF.
- With the macro defined: word 0x40 = 0x11223344, MEM write 0xAABBCCDD with sel=0101, then read -> 0x11BB33DD. Without the macro -> 0xAABBCCDD.
- Address 0x1004 (DEPTH_LOG2=10) read -> returns word 1 (wrap); a re pulse while busy_o=1 -> no extra done.
- Assert rst=0 in cycle 1 of a pending MEM write to 0x8 (old 0x0) -> all outputs 0 immediately, no done after release, word 2 still 0x0.

Source files
------------

// File: rtl/mem_responder.sv
// Dual-initiator single-port word memory: IF read port, MEM read/write port.
// MEM_RESPONDER_BYTE_SEL_EN enables per-byte MEM write enables.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_re_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_data_o,
  output logic                  if_busy_o,
  output logic                  if_done_o,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [3:0]            mem_sel_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_busy_o,
  output logic                  mem_done_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IW    = DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_MEM,
    SERVE_IF
  } state_e;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  mem_pend_q, mem_pend_d;
  logic                  mem_busy_q, mem_busy_d;
  logic                  mem_we_q, mem_we_d;
  logic [IW-1:0]         mem_idx_q, mem_idx_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_sel_q, mem_sel_d;
  logic                  if_pend_q, if_pend_d;
  logic                  if_busy_q, if_busy_d;
  logic [IW-1:0]         if_idx_q, if_idx_d;
  logic                  mem_done_q, mem_done_d;
  logic                  if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_WIDTH-1:0] if_data_q, if_data_d;

  logic          mem_acc, if_acc;
  logic          serving, fin, fin_mem;
  logic          mem_cand, if_cand, free;
  logic          start_mem, start_if;
  logic          ent_mem, ent_if;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [IW-1:0] mem_idx_s, if_idx_s;
  logic          mem_we_s;
  logic [DATA_WIDTH-1:0] mem_rd_word, if_rd_word;
  logic          unused_addr;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    end
    return r;
  endfunction

`ifdef MEM_RESPONDER_BYTE_SEL_EN
  assign wr_be = mem_sel_q;
`else
  logic unused_sel;
  assign wr_be      = 4'hF;
  assign unused_sel = ^mem_sel_q;
`endif

  assign unused_addr = ^{mem_addr_i[1:0], mem_addr_i[ADDR_WIDTH-1:IW+2],
                         if_addr_i[1:0], if_addr_i[ADDR_WIDTH-1:IW+2]};

  always_comb begin
    mem_acc   = (mem_re_i | mem_we_i) & ~mem_busy_q;
    if_acc    = if_re_i & ~if_busy_q;
    serving   = state_q != IDLE;
    fin       = serving && cnt_q == 4'd0;
    fin_mem   = fin && state_q == SERVE_MEM;
    mem_idx_s = mem_acc ? mem_addr_i[IW+1:2] : mem_idx_q;
    mem_we_s  = mem_acc ? mem_we_i : mem_we_q;
    if_idx_s  = if_acc ? if_addr_i[IW+1:2] : if_idx_q;
    // a slot waiting behind the other port, or a fresh request, may start
    mem_cand  = mem_acc || (mem_pend_q && state_q != SERVE_MEM);
    if_cand   = if_acc || (if_pend_q && state_q != SERVE_IF);
    free      = !serving || fin;
    start_mem = free && mem_cand;
    start_if  = free && !mem_cand && if_cand;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_mem) begin
      state_d = SERVE_MEM;
      cnt_d   = CNT_INIT;
    end else if (start_if) begin
      state_d = SERVE_IF;
      cnt_d   = CNT_INIT;
    end else if (fin) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (serving) begin
      cnt_d = cnt_q - 4'd1;
    end

    ent_mem = state_d == SERVE_MEM && cnt_d == 4'd0;
    ent_if  = state_d == SERVE_IF && cnt_d == 4'd0;
    wr_en   = fin_mem && mem_we_q && rst;

    // reads landing on the edge that commits a write see the new bytes
    mem_rd_word = ram[mem_idx_s];
    if (wr_en && mem_idx_q == mem_idx_s) begin
      mem_rd_word = merge(ram[mem_idx_s], mem_wdata_q, wr_be);
    end
    if_rd_word = ram[if_idx_s];
    if (wr_en && mem_idx_q == if_idx_s) begin
      if_rd_word = merge(ram[if_idx_s], mem_wdata_q, wr_be);
    end

    mem_pend_d  = mem_acc ? 1'b1 : (fin_mem ? 1'b0 : mem_pend_q);
    mem_we_d    = mem_acc ? mem_we_i : mem_we_q;
    mem_idx_d   = mem_idx_s;
    mem_wdata_d = mem_acc ? mem_wdata_i : mem_wdata_q;
    mem_sel_d   = mem_acc ? mem_sel_i : mem_sel_q;
    if_pend_d   = if_acc ? 1'b1 : ((fin && state_q == SERVE_IF) ? 1'b0 : if_pend_q);
    if_idx_d    = if_idx_s;

    mem_busy_d  = mem_pend_d && !ent_mem;
    if_busy_d   = if_pend_d && !ent_if;
    mem_done_d  = ent_mem;
    if_done_d   = ent_if;
    mem_rdata_d = (ent_mem && !mem_we_s) ? mem_rd_word : mem_rdata_q;
    if_data_d   = ent_if ? if_rd_word : if_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mem_pend_q  <= 1'b0;
      mem_busy_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_idx_q   <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= 4'd0;
      if_pend_q   <= 1'b0;
      if_busy_q   <= 1'b0;
      if_idx_q    <= '0;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      if_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_pend_q  <= mem_pend_d;
      mem_busy_q  <= mem_busy_d;
      mem_we_q    <= mem_we_d;
      mem_idx_q   <= mem_idx_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      if_pend_q   <= if_pend_d;
      if_busy_q   <= if_busy_d;
      if_idx_q    <= if_idx_d;
      mem_done_q  <= mem_done_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      if_data_q   <= if_data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) begin
        ram[mem_idx_q][8*b +: 8] <= mem_wdata_q[8*b +: 8];
      end
    end
  end

  assign if_data_o   = if_data_q;
  assign if_busy_o   = if_busy_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_busy_o  = mem_busy_q;
  assign mem_done_o  = mem_done_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected done cycle and data per port.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_re_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_busy_o, if_done_o;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_busy_o, mem_done_o;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .if_re_i(if_re_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_busy_o(if_busy_o), .if_done_o(if_done_o),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
    .mem_rdata_o(mem_rdata_o), .mem_busy_o(mem_busy_o), .mem_done_o(mem_done_o)
  );

  localparam logic [31:0] A0 = 32'h00500093;
  localparam logic [31:0] A1 = 32'h00100113;
  localparam logic [31:0] A2 = 32'h002081B3;
`ifdef MEM_RESPONDER_BYTE_SEL_EN
  localparam logic [31:0] BYTE_EXP = 32'h11BB33DD;
  localparam logic [31:0] ZERO_EXP = 32'h11BB33DD;
`else
  localparam logic [31:0] BYTE_EXP = 32'hAABBCCDD;
  localparam logic [31:0] ZERO_EXP = 32'hFFFFFFFF;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          rd;
  } exp_t;

  exp_t q_if[$];
  exp_t q_mem[$];
  exp_t ei, em;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (if_done_o) begin
      if (q_if.size() == 0) chk("if_unexpected_done", 32'd1, 32'd0);
      else begin
        ei = q_if.pop_front();
        chk("if_done_cycle", cyc, ei.cyc);
        chk("if_data", if_data_o, ei.data);
      end
    end
    if (mem_done_o) begin
      if (q_mem.size() == 0) chk("mem_unexpected_done", 32'd1, 32'd0);
      else begin
        em = q_mem.pop_front();
        chk("mem_done_cycle", cyc, em.cyc);
        if (em.rd) chk("mem_rdata", mem_rdata_o, em.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic mem_op(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp);
    int c0;
    c0 = cyc;
    mem_we_i = we;
    mem_re_i = !we;
    mem_addr_i = a;
    mem_wdata_i = d;
    mem_sel_i = s;
    q_mem.push_back('{c0 + 3, exp, !we});
    tick();
    mem_we_i = 1'b0;
    mem_re_i = 1'b0;
    chk("mem_busy", {31'd0, mem_busy_o}, 32'd1);
    idle_to(c0 + 4);
  endtask

  task automatic if_rd(input logic [31:0] a, input logic [31:0] exp);
    int c0;
    c0 = cyc;
    if_re_i = 1'b1;
    if_addr_i = a;
    q_if.push_back('{c0 + 3, exp, 1'b1});
    tick();
    if_re_i = 1'b0;
    chk("if_busy_c1", {31'd0, if_busy_o}, 32'd1);
    tick();
    chk("if_busy_c2", {31'd0, if_busy_o}, 32'd1);
    tick();
    chk("if_busy_done", {31'd0, if_busy_o}, 32'd0);
    idle_to(c0 + 4);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_if_data"}, if_data_o, 32'd0);
    chk({nm, "_mem_rdata"}, mem_rdata_o, 32'd0);
    chk({nm, "_flags"},
        {26'd0, if_busy_o, if_done_o, mem_busy_o, mem_done_o, 2'b00}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    #2;
    chk_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    mem_op(1'b1, 32'h10, 32'h13, 4'hF, 32'd0);
    mem_op(1'b1, 32'h00, A0, 4'hF, 32'd0);
    mem_op(1'b1, 32'h04, A1, 4'hF, 32'd0);
    mem_op(1'b1, 32'h08, A2, 4'hF, 32'd0);

    if_rd(32'h10, 32'h13);
    tick();
    tick();
    chk("if_data_hold", if_data_o, 32'h13);

    c0 = cyc;
    if_re_i = 1'b1;
    if_addr_i = 32'h0;
    q_if.push_back('{c0 + 3, A0, 1'b1});
    q_if.push_back('{c0 + 6, A1, 1'b1});
    q_if.push_back('{c0 + 9, A2, 1'b1});
    idle_to(c0 + 3);
    if_addr_i = 32'h4;
    idle_to(c0 + 6);
    if_addr_i = 32'h8;
    idle_to(c0 + 9);
    if_re_i = 1'b0;
    idle_to(c0 + 10);

    c0 = cyc;
    mem_we_i = 1'b1;
    mem_addr_i = 32'h20;
    mem_wdata_i = 32'hDEADBEEF;
    mem_sel_i = 4'hF;
    if_re_i = 1'b1;
    if_addr_i = 32'h20;
    q_mem.push_back('{c0 + 3, 32'd0, 1'b0});
    q_if.push_back('{c0 + 6, 32'hDEADBEEF, 1'b1});
    tick();
    mem_we_i = 1'b0;
    if_re_i = 1'b0;
    chk("queued_if_busy", {31'd0, if_busy_o}, 32'd1);
    idle_to(c0 + 7);

    mem_op(1'b1, 32'h40, 32'h11223344, 4'hF, 32'd0);
    mem_op(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 32'd0);
    mem_op(1'b0, 32'h40, 32'd0, 4'h0, BYTE_EXP);
    tick();
    chk("mem_rdata_hold", mem_rdata_o, BYTE_EXP);
    mem_op(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 32'd0);
    mem_op(1'b0, 32'h40, 32'd0, 4'h0, ZERO_EXP);

    c0 = cyc;
    if_re_i = 1'b1;
    if_addr_i = 32'h1004;
    q_if.push_back('{c0 + 3, A1, 1'b1});
    tick();
    if_addr_i = 32'h8;
    tick();
    if_re_i = 1'b0;
    idle_to(c0 + 8);
    mem_op(1'b0, 32'h1008, 32'd0, 4'h0, A2);

    mem_op(1'b1, 32'h08, 32'd0, 4'hF, 32'd0);
    mem_op(1'b0, 32'h04, 32'd0, 4'h0, A1);
    mem_we_i = 1'b1;
    mem_addr_i = 32'h08;
    mem_wdata_i = 32'h55;
    mem_sel_i = 4'hF;
    tick();
    mem_we_i = 1'b0;
    chk("abort_busy_before", {31'd0, mem_busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk_zero("abort");
    tick();
    tick();
    rst = 1'b1;
    idle_to(cyc + 5);
    mem_op(1'b0, 32'h08, 32'd0, 4'h0, 32'd0);

    idle_to(cyc + 3);
    chk("sb_if_empty", q_if.size(), 32'd0);
    chk("sb_mem_empty", q_mem.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
